store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Posted-write FIFO between the MEM stage and data_memory. Stores retire in one cycle into the
//   buffer and drain one per cycle into data_memory whenever its single address port is idle.
//   Loads read data_memory combinationally; they are checked against pending stores so that no
//   load returns stale data.
// PARAMETERS
//   DATA_WIDTH  32  data/address width
//   BYTE_WIDTH  8   byte width; word = 4 bytes
//   DEPTH       4   buffer entries, power of two, >= 2
// PORTS
//   clk            in   1           clock, rising edge
//   rst            in   1           synchronous reset, active-high
//   we_i           in   1           store request from MEM stage
//   re_i           in   1           load request from MEM stage
//   byte_op_i      in   1           1 = byte (SB/LBU), 0 = word (SW/LW)
//   addr_i         in   DATA_WIDTH  byte address
//   wd_i           in   DATA_WIDTH  store data
//   fence_i        in   1           hold the pipeline until buffer empty
//   rd_o           out  DATA_WIDTH  load data (LBU zero-extended)
//   stall_o        out  1           combinational; MEM stage must hold its request
//   empty_o        out  1           no pending stores
//   mem_we_o       out  1           to data_memory we_i
//   mem_byte_op_o  out  1           to data_memory byte_op_i
//   mem_addr_o     out  DATA_WIDTH  to data_memory addr_i
//   mem_wd_o       out  DATA_WIDTH  to data_memory wd_i
//   mem_rd_i       in   DATA_WIDTH  from data_memory rd_o
// BEHAVIOUR
//   - Entry = {addr, data, byte_op, 4-bit byte mask}. Word stores: addr & ~3, mask 4'b1111.
//     Byte stores: mask = 1 << addr[1:0], data in bits [7:0].
//   - Circular FIFO: head/tail pointers plus a count of 0..DEPTH. full = (count == DEPTH).
//   - Enqueue: at posedge when we_i && !full. The entry is visible to the overlap check and
//     eligible to drain from the next cycle.
//   - Store while full: stall_o = 1; accepted in the first cycle after count < DEPTH.
//   - we_i && re_i together is illegal and handled as a store; rd_o = 0.
//   - Port arbitration each cycle:
//     - A load whose bytes do not overlap any valid entry owns the port:
//       mem_we_o = 0, mem_addr_o = addr_i, mem_byte_op_o = byte_op_i, rd_o = mem_rd_i.
//     - Otherwise, if count > 0, the head drains:
//       mem_we_o = 1, mem_addr_o/mem_wd_o/mem_byte_op_o = head fields.
//       The pop happens at posedge; data_memory writes on negedge of the same cycle.
//   - Simultaneous enqueue and pop is legal: count is unchanged and both pointers advance.
//   - Overlap check: load mask versus each valid entry's mask for the same word address.
//     Youngest overlapping entry wins.
//   - fence_i: stall_o = 1 while count > 0. The buffer keeps draining.
//   - Idle (no load on the port, count == 0): mem_* = 0, rd_o = 0.
//   - Reset value of all outputs: 0, except empty_o = 1.
//   - Reset: count, head and tail go to 0 in the reset cycle and pending stores are discarded.
//     Reset mid-drain is legal; the write on that negedge may still occur.
// CONFIGURATION
//   STORE_FWD_EN defined:
//     - If the youngest overlapping entry's mask is a superset of the load mask, rd_o is built
//       from that entry. Byte load from a word entry: zero-extended byte at addr[1:0].
//     - The load finishes in the same cycle, stall_o = 0, and the head may drain that cycle.
//     - Partial coverage: stall_o = 1 while the drain proceeds; recheck every cycle.
//   STORE_FWD_EN undefined:
//     - Any overlap gives stall_o = 1 until the overlapping entries drain, then the load reads
//       data_memory.
// TESTING
//   1. Reset, then SW 0x10000 <= 0xDEADBEEF. Expect: stall_o = 0; next cycle mem_we_o = 1,
//      mem_addr_o = 0x10000; empty_o = 1 afterwards.
//   2. DEPTH + 1 back-to-back SW with no loads. Expect: the 5th store is not stalled, because
//      a pop happens in the same cycle. Then hold re_i non-overlapping loads so no drain
//      occurs, fill to 4, and issue a store: stall_o = 1 until a drain slot frees.
//   3. SW 0x10004 <= 0x11223344, then LBU 0x10006 next cycle.
//      - FWD_EN: rd_o = 0x22, stall_o = 0.
//      - Without FWD_EN: stall_o = 1 for 1 cycle, then rd_o = 0x22 from memory.
//   4. SB 0x10008 <= 0xAA, then LW 0x10008 (partial coverage). Expect: stall_o = 1 until
//      drained, then rd_o = {mem bytes, 0xAA} in both configurations.
//   5. Non-overlapping LW 0x10100 with 2 pending stores. Expect: rd_o = mem_rd_i the same
//      cycle, mem_we_o = 0, count unchanged.
//   6. 3 pending stores, assert rst for 1 cycle. Expect: empty_o = 1, mem_we_o = 0 next cycle,
//      and no further writes to data_memory.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and data_memory, with a load/store overlap check.
// Define STORE_FWD_EN to forward load data from the youngest fully covering pending store.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic                  byte_op_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic                  fence_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  stall_o,
    output logic                  empty_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  byte_op;
        logic [3:0]            mask;
    } entry_t;

    entry_t            entries [DEPTH];
    entry_t            new_entry;
    entry_t            head_entry;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  match;
    logic [3:0]        lmask;
    logic              full;
    logic              load;
    logic              overlap;
    logic              port_load;
    logic              drain;
    logic              push;
    logic              fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    assign full       = (count == CW'(DEPTH));
    assign load       = re_i && !we_i;
    assign lmask      = byte_op_i ? (4'b0001 << addr_i[1:0]) : 4'b1111;
    assign head_entry = entries[head];

    always_comb begin
        new_entry.byte_op = byte_op_i;
        new_entry.mask    = lmask;
        new_entry.addr    = byte_op_i ? addr_i : {addr_i[DATA_WIDTH-1:2], 2'b00};
        new_entry.data    = byte_op_i ? DATA_WIDTH'(wd_i[BYTE_WIDTH-1:0]) : wd_i;
    end

    // match[i] refers to the i-th oldest valid entry, so the highest set bit is the youngest.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count
                && entries[PW'(head + PW'(i))].addr[DATA_WIDTH-1:2] == addr_i[DATA_WIDTH-1:2]
                && (entries[PW'(head + PW'(i))].mask & lmask) != 4'b0000) begin
                match[i] = 1'b1;
            end
        end
    end

    assign overlap = |match;

`ifdef STORE_FWD_EN
    localparam int SHW = $clog2(DATA_WIDTH);
    logic [PW-1:0]         hit_idx;
    entry_t                hit_entry;
    logic [SHW-1:0]        fwd_shift;
    logic [DATA_WIDTH-1:0] fwd_shifted;

    always_comb begin
        hit_idx = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                hit_idx = PW'(head + PW'(i));
            end
        end
    end

    assign hit_entry   = entries[hit_idx];
    assign fwd_hit     = load && overlap && ((hit_entry.mask & lmask) == lmask);
    // Byte entries already hold their byte in the low lane; word entries need the lane selected.
    assign fwd_shift   = hit_entry.byte_op ? '0 : SHW'(addr_i[1:0]) * SHW'(BYTE_WIDTH);
    assign fwd_shifted = hit_entry.data >> fwd_shift;
    assign fwd_data    = byte_op_i ? (fwd_shifted & DATA_WIDTH'({BYTE_WIDTH{1'b1}}))
                                   : hit_entry.data;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // A non-overlapping re_i claims the port even alongside we_i, so stores can queue behind it.
    assign port_load = re_i && !overlap;
    assign drain     = !port_load && (count != '0);
    assign push      = we_i && !full;
    assign empty_o   = (count == '0);
    assign stall_o   = (we_i && full) || (load && overlap && !fwd_hit) || (fence_i && count != '0);

    always_comb begin
        rd_o          = '0;
        mem_we_o      = 1'b0;
        mem_byte_op_o = 1'b0;
        mem_addr_o    = '0;
        mem_wd_o      = '0;
        if (port_load) begin
            mem_addr_o    = addr_i;
            mem_byte_op_o = byte_op_i;
            if (load) begin
                rd_o = mem_rd_i;
            end
        end else if (drain) begin
            mem_we_o      = 1'b1;
            mem_addr_o    = head_entry.addr;
            mem_wd_o      = head_entry.data;
            mem_byte_op_o = head_entry.byte_op;
        end
        if (fwd_hit) begin
            rd_o = fwd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[tail] <= new_entry;
                tail          <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a pending-store queue model.
// Includes a small byte-addressed data_memory stand-in covering 0x10000..0x101FF.
module tb_store_buffer;
    localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, we, re, byte_op, fence;
    logic [31:0] addr, wd, rd, mem_addr, mem_wd, mem_rd;
    logic        stall, empty, mem_we, mem_byte_op;

    store_buffer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .we_i(we), .re_i(re), .byte_op_i(byte_op),
        .addr_i(addr), .wd_i(wd), .fence_i(fence), .rd_o(rd), .stall_o(stall),
        .empty_o(empty), .mem_we_o(mem_we), .mem_byte_op_o(mem_byte_op),
        .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(int unsigned i);
        return 8'((i * 29 + 7) ^ (i >> 3));
    endfunction

    // data_memory stand-in: combinational read, write on negedge
    logic [7:0] mem [512];
    bit         mem_ready = 1'b0;

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] = init_byte(i);
            mem_ready = 1'b1;
        end else if (mem_we && mem_addr[31:9] == 23'h80) begin
            if (mem_byte_op) mem[mem_addr[8:0]] = mem_wd[7:0];
            else for (int k = 0; k < 4; k++) mem[{mem_addr[8:2], 2'(k)}] = mem_wd[8*k +: 8];
        end
    end

    always_comb begin
        mem_rd = 32'hBAD0_BAD0;
        if (mem_addr[31:9] == 23'h80) begin
            if (mem_byte_op) mem_rd = {24'h0, mem[mem_addr[8:0]]};
            else mem_rd = {mem[{mem_addr[8:2], 2'd3}], mem[{mem_addr[8:2], 2'd2}],
                           mem[{mem_addr[8:2], 2'd1}], mem[{mem_addr[8:2], 2'd0}]};
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: architectural memory after drains plus the ordered list of pending stores.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          bo;
        logic [3:0]  mask;
    } st_t;

    st_t        q[$];
    logic [7:0] ref_mem [512];

    function automatic logic [31:0] arch_value(logic [31:0] a, bit bo);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = ref_mem[{a[8:2], 2'(k)}];
        foreach (q[i])
            if (q[i].addr[31:2] == a[31:2])
                for (int k = 0; k < 4; k++)
                    if (q[i].mask[k]) b[k] = q[i].bo ? q[i].data[7:0] : q[i].data[8*k +: 8];
        if (bo) return {24'h0, b[a[1:0]]};
        return {b[3], b[2], b[1], b[0]};
    endfunction

    logic        last_stall, last_we, last_empty;
    logic [31:0] last_rd, last_maddr;

    task automatic step(input bit r, input bit w, input bit l, input bit bo,
                        input logic [31:0] a, input logic [31:0] d, input bit f);
        bit          ov, cov, port, ld, exp_we, exp_stall, do_push;
        logic [3:0]  lm, ymask;
        logic [31:0] av;
        st_t         e;
        @(posedge clk);
        #1;
        rst = r; we = w; re = l; byte_op = bo; addr = a; wd = d; fence = f;
        #3;
        lm = bo ? 4'(1 << a[1:0]) : 4'hF;
        ov = 1'b0; ymask = 4'h0;
        foreach (q[i])
            if (q[i].addr[31:2] == a[31:2] && (q[i].mask & lm) != 4'h0) begin
                ov = 1'b1; ymask = q[i].mask;
            end
        cov       = FWD && ov && ((ymask & lm) == lm);
        ld        = l && !w;
        port      = l && !ov;
        exp_we    = !port && q.size() > 0;
        exp_stall = (w && q.size() == DEPTH) || (ld && ov && !cov) || (f && q.size() > 0);
        av        = arch_value(a, bo);
        if (!r) begin
            check("stall", stall, exp_stall);
            check("empty", empty, q.size() == 0);
            check("mem_we", mem_we, exp_we);
            if (exp_we) begin
                check("drain_addr", mem_addr, q[0].addr);
                check("drain_wd", mem_wd, q[0].data);
                check("drain_bo", mem_byte_op, q[0].bo);
            end
            if (port) begin
                check("load_addr", mem_addr, a);
                check("load_bo", mem_byte_op, bo);
            end
            if (ld && (!ov || cov)) check("load_rd", rd, av);
            if (w && l) check("rd_illegal", rd, 32'h0);
            if (!port && q.size() == 0) begin
                check("idle_addr", mem_addr, 32'h0);
                check("idle_wd", mem_wd, 32'h0);
                check("idle_bo", mem_byte_op, 1'b0);
                check("idle_rd", rd, 32'h0);
            end
        end
        last_stall = stall; last_we = mem_we; last_empty = empty;
        last_rd = rd; last_maddr = mem_addr;
        do_push = !r && w && q.size() < DEPTH;
        if (exp_we) begin
            for (int k = 0; k < 4; k++)
                if (q[0].mask[k])
                    ref_mem[{q[0].addr[8:2], 2'(k)}] = q[0].bo ? q[0].data[7:0] : q[0].data[8*k +: 8];
        end
        if (r) begin
            q.delete();
        end else begin
            if (exp_we) void'(q.pop_front());
            if (do_push) begin
                e.bo   = bo;
                e.mask = lm;
                e.addr = bo ? a : {a[31:2], 2'b00};
                e.data = bo ? {24'h0, d[7:0]} : d;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic drain_all(input string tag);
        int n = 0;
        do begin
            idle();
            n++;
        end while (!last_empty && n < 2 * DEPTH + 4);
        check(tag, last_empty, 1'b1);
    endtask

    bit          rr, rw, rl, rbo, rf;
    logic [31:0] ra, rdat;
    int unsigned kind, hold_cnt;

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1; we = 1'b0; re = 1'b0; byte_op = 1'b0; fence = 1'b0;
        addr = '0; wd = '0;
        repeat (3) step(1, 0, 0, 0, 32'h0, 32'h0, 0);

        // 1: single word store, drains next cycle
        idle();
        check("t1_reset_empty", last_empty, 1'b1);
        step(0, 1, 0, 0, 32'h10000, 32'hDEADBEEF, 0);
        check("t1_stall", last_stall, 1'b0);
        idle();
        check("t1_we", last_we, 1'b1);
        check("t1_addr", last_maddr, 32'h10000);
        idle();
        check("t1_empty", last_empty, 1'b1);

        // 2: back-to-back stores, then fill behind held loads
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(0, 1, 0, 0, 32'h10020 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 0);
            check("t2_no_stall", last_stall, 1'b0);
        end
        drain_all("t2_drain_bound");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 32'h10040 + 32'(4 * i), 32'h5500 + 32'(i), 0);
        step(0, 1, 1, 0, 32'h10050, 32'h0000_7777, 0);
        check("t2_full_stall", last_stall, 1'b1);
        begin
            int n = 0;
            do begin
                step(0, 1, 0, 0, 32'h10050, 32'h0000_7777, 0);
                n++;
            end while (last_stall && n < 10);
            check("t2_accept", last_stall, 1'b0);
        end
        drain_all("t2_drain_bound2");

        // 3: byte load under a pending word store
        step(0, 1, 0, 0, 32'h10004, 32'h11223344, 0);
        step(0, 0, 1, 1, 32'h10006, 32'h0, 0);
`ifdef STORE_FWD_EN
        check("t3_fwd_stall", last_stall, 1'b0);
        check("t3_fwd_rd", last_rd, 32'h22);
`else
        check("t3_stall", last_stall, 1'b1);
        step(0, 0, 1, 1, 32'h10006, 32'h0, 0);
        check("t3_stall_clear", last_stall, 1'b0);
        check("t3_rd", last_rd, 32'h22);
`endif
        drain_all("t3_drain_bound");

        // 4: word load partially covered by a byte store
        step(0, 1, 0, 1, 32'h10008, 32'h0000_00AA, 0);
        begin
            int n = 0;
            do begin
                step(0, 0, 1, 0, 32'h10008, 32'h0, 0);
                n++;
            end while (last_stall && n < 10);
            check("t4_stall_bound", last_stall, 1'b0);
            check("t4_rd_low", {24'h0, last_rd[7:0]}, 32'hAA);
        end

        // 5: non-overlapping load with two pending stores
        drain_all("t5_drain_bound");
        step(0, 1, 1, 0, 32'h10010, 32'h0BAD_F00D, 0);
        step(0, 1, 1, 0, 32'h10014, 32'h1234_5678, 0);
        step(0, 0, 1, 0, 32'h10100, 32'h0, 0);
        check("t5_we", last_we, 1'b0);
        check("t5_addr", last_maddr, 32'h10100);
        idle();
        check("t5_drain_first", last_maddr, 32'h10010);
        drain_all("t5_drain_bound2");

        // 6: reset discards pending stores
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h10060 + 32'(4 * i), 32'hFFFF_0000 + 32'(i), 0);
        step(1, 0, 1, 0, 32'h10100, 32'h0, 0);
        idle();
        check("t6_empty", last_empty, 1'b1);
        check("t6_we", last_we, 1'b0);
        step(0, 0, 1, 0, 32'h10060, 32'h0, 0);
        check("t6_discarded", last_rd, {init_byte(32'h63), init_byte(32'h62),
                                        init_byte(32'h61), init_byte(32'h60)});

        // randomized traffic; stalled requests are held for a while like a real MEM stage
        hold_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            if (last_stall && hold_cnt < 8) begin
                hold_cnt++;
                step(0, rw, rl, rbo, ra, rdat, rf);
            end else begin
                hold_cnt = 0;
                kind = $urandom_range(0, 99);
                ra   = ($urandom_range(0, 4) == 0) ? 32'h10100 + 32'($urandom_range(0, 15))
                                                   : 32'h10000 + 32'($urandom_range(0, 23));
                rbo  = 1'($urandom_range(0, 1));
                if (!rbo) ra[1:0] = 2'b00;
                rdat = $urandom();
                rf   = ($urandom_range(0, 9) == 0);
                rw   = (kind < 30) || (kind >= 60 && kind < 70);
                rl   = (kind >= 30 && kind < 70);
                if (kind >= 70 && kind < 75) rf = 1'b1;
                rr   = (kind == 75);
                step(rr, rw, rl, rbo, ra, rdat, rf);
            end
        end
        drain_all("final_drain_bound");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
